// File: rtl/cpu_pkg.sv
// Shared constants and types for the stack controller slice.
package cpu_pkg;

  localparam int WIDTH_DEF   = 8;
  localparam int STACK_BASE  = 8'hC0;
  localparam int STACK_DEPTH = 32;

  // state   | meaning
  // IDLE    | accept push/pop or grant CPU load/store
  // POP_RD  | memory read data for the pop is on mem_d_out
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_POP_RD = 1'b1
  } stack_state_t;

endpackage

// File: rtl/stack_ptr.sv
// Stack depth counter with full/empty decode.
module stack_ptr #(
  parameter int DEPTH = 32,
  parameter int DW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          dec,
  output logic [DW-1:0] depth,
  output logic          full,
  output logic          empty
);

  assign full  = (depth == DW'(DEPTH));
  assign empty = (depth == '0);

  // Count up on an accepted push, down on an accepted pop; saturating guards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth <= '0;
    end else if (inc && !dec && !full) begin
      depth <= depth + DW'(1);
    end else if (dec && !inc && !empty) begin
      depth <= depth - DW'(1);
    end
  end

endmodule

// File: rtl/stack_ctrl.sv
// Hardware stack controller; sole master of the data memory port.
// Stack operations take the port first; CPU load/store is granted otherwise.
module stack_ctrl
  import cpu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int BASE  = STACK_BASE,
  parameter int DEPTH = STACK_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           d_push,
  output logic [WIDTH-1:0]           d_pop,
  output logic                       pop_valid,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       full,
  output logic                       empty,
  output logic                       ovf,
  output logic                       unf,
  input  logic                       clr_err,
  input  logic                       ls_req,
  input  logic                       ls_we,
  input  logic [WIDTH-1:0]           ls_addr,
  input  logic [WIDTH-1:0]           ls_wdata,
  output logic                       ls_gnt,
  output logic                       mem_en,
  output logic [WIDTH-1:0]           mem_addr,
  output logic [WIDTH-1:0]           mem_d_in,
  input  logic [WIDTH-1:0]           mem_d_out
);

  localparam int DW = $clog2(DEPTH + 1);

  if (BASE + DEPTH > (1 << WIDTH)) begin : g_window_check
    $error("stack window BASE+DEPTH exceeds the address space");
  end

  stack_state_t     state, state_nxt;
  logic             inc, dec;
  logic             stack_acc, stack_we;
  logic             ovf_set, unf_set;
  logic [WIDTH-1:0] stack_addr;
  logic [WIDTH-1:0] top_addr, top_addr_m1;
  logic [WIDTH-1:0] d_pop_q;

  stack_ptr #(.DEPTH(DEPTH), .DW(DW)) u_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc),
    .dec   (dec),
    .depth (depth),
    .full  (full),
    .empty (empty)
  );

  assign top_addr    = WIDTH'(BASE) + WIDTH'(depth);
  assign top_addr_m1 = top_addr - WIDTH'(1);

  // State register, sticky flags and held pop data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      ovf     <= 1'b0;
      unf     <= 1'b0;
      d_pop_q <= '0;
    end else begin
      state <= state_nxt;
      if (ovf_set)      ovf <= 1'b1;
      else if (clr_err) ovf <= 1'b0;
      if (unf_set)      unf <= 1'b1;
      else if (clr_err) unf <= 1'b0;
      if (state == ST_POP_RD) d_pop_q <= mem_d_out;
    end
  end

  // Next state and stack-side memory request.
  always_comb begin
    state_nxt  = state;
    inc        = 1'b0;
    dec        = 1'b0;
    stack_acc  = 1'b0;
    stack_we   = 1'b0;
    stack_addr = ls_addr;
    ovf_set    = 1'b0;
    unf_set    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (push && pop && !empty) begin
          // replace-top: overwrite the top entry, depth unchanged
          stack_acc  = 1'b1;
          stack_we   = 1'b1;
          stack_addr = top_addr_m1;
        end else if (push) begin
          if (!full) begin
            stack_acc  = 1'b1;
            stack_we   = 1'b1;
            stack_addr = top_addr;
            inc        = 1'b1;
          end else begin
            ovf_set = 1'b1;
          end
        end else if (pop) begin
          if (!empty) begin
            stack_acc  = 1'b1;
            stack_addr = top_addr_m1;
            dec        = 1'b1;
            state_nxt  = ST_POP_RD;
          end else begin
            unf_set = 1'b1;
          end
        end
      end
      ST_POP_RD: begin
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Port arbitration; everything is held off while reset is asserted.
  always_comb begin
    ls_gnt    = rst_n && ls_req && !stack_acc;
    mem_en    = 1'b0;
    mem_addr  = ls_addr;
    mem_d_in  = ls_wdata;
    if (stack_acc) begin
      mem_en   = rst_n && stack_we;
      mem_addr = stack_addr;
      mem_d_in = d_push;
    end else if (ls_gnt) begin
      mem_en = ls_we;
    end
    pop_valid = (state == ST_POP_RD);
    busy      = (state == ST_POP_RD);
    d_pop     = (state == ST_POP_RD) ? mem_d_out : d_pop_q;
  end

endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
- Hardware stack controller placed directly upstream of data_mem; sole master of data_mem's port.
- Maps PUSH/POP requests from the control unit onto a fixed window of data memory.
- Muxes ordinary CPU load/store traffic onto the same port; stack operations win on conflict.
- Tracks stack depth and full/empty state, with sticky overflow/underflow flags.

Parameters:
- WIDTH, 8: data and address width; must equal data_mem WIDTH.
- BASE, 8'hC0: lowest data_mem address of the stack window; entry 0 lives here.
- DEPTH, 32: number of stack entries. BASE+DEPTH <= 2**WIDTH is enforced by an elaboration-time check.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- push  in  1  push request, one op per high cycle.
- pop  in  1  pop request.
- d_push  in  WIDTH  data to push.
- d_pop  out  WIDTH  popped data.
- pop_valid  out  1  d_pop valid strobe.
- busy  out  1  high while a pop read is in flight.
- depth  out  $clog2(DEPTH+1)  current entry count.
- full  out  1  depth==DEPTH.
- empty  out  1  depth==0.
- ovf  out  1  sticky overflow flag.
- unf  out  1  sticky underflow flag.
- clr_err  in  1  synchronous clear of ovf/unf.
- ls_req  in  1  CPU load/store request.
- ls_we  in  1  1 = store, 0 = load.
- ls_addr  in  WIDTH  CPU address.
- ls_wdata  in  WIDTH  CPU store data.
- ls_gnt  out  1  CPU access owns memory this cycle.
- mem_en  out  1  data_mem write enable (drives en).
- mem_addr  out  WIDTH  to data_mem addr.
- mem_d_in  out  WIDTH  to data_mem d_in.
- mem_d_out  in  WIDTH  from data_mem d_out.

Behaviour:
- Memory contract:
  - data_mem writes mem[addr]<=d_in on the rising edge when en=1.
  - d_out is registered: it shows mem[addr] one cycle after addr is presented.
- Reset (async, rst_n=0):
  - State IDLE; depth=0, empty=1, full=0, ovf=0, unf=0.
  - d_pop=0, pop_valid=0, busy=0, ls_gnt=0, mem_en forced 0.
  - Takes effect immediately, including mid-pop; an in-flight pop is dropped.
- FSM states are IDLE and POP_RD.
- IDLE, push only, !full:
  - Same cycle: mem_en=1, mem_addr=BASE+depth, mem_d_in=d_push.
  - Next edge: depth+1.
- IDLE, push only, full: no memory access; ovf<=1; depth unchanged.
- IDLE, pop only, !empty:
  - Same cycle: mem_en=0, mem_addr=BASE+depth-1.
  - Next edge: depth-1, state->POP_RD.
- IDLE, pop only, empty: no access; unf<=1; stay IDLE.
- IDLE, push and pop together:
  - depth>0 (replace-top): write d_push to BASE+depth-1; depth unchanged; no pop data.
  - depth==0: behaves as push alone.
- POP_RD (exactly one cycle):
  - busy=1, pop_valid=1, d_pop=mem_d_out.
  - At the edge, d_pop register captures mem_d_out and holds it until the next pop.
  - push/pop in this cycle are ignored, with no flag change.
  - Next state: IDLE.
- Arbitration:
  - ls_gnt=1 when ls_req=1 and the stack makes no memory access this cycle (IDLE with no push/pop, POP_RD, or a rejected full/empty op).
  - While ls_gnt=1: mem_en=ls_we, mem_addr=ls_addr, mem_d_in=ls_wdata.
  - With no stack access and no ls grant: mem_en=0, mem_addr=ls_addr.
  - A denied CPU request must be held by the requester until granted.
- Flags:
  - ovf and unf stay set until clr_err=1 or reset.
  - clr_err coinciding with a new fault: the set wins.
- Address arithmetic: modulo 2**WIDTH; no wrap occurs inside a legal window.
- full/empty are combinational from depth; pop_valid is a one-cycle pulse.

Decomposition:
- Shared package cpu_pkg holds:
  - the FSM state enum (ST_IDLE, ST_POP_RD);
  - the default WIDTH constant;
  - the stack window constants STACK_BASE and STACK_DEPTH.
- Optional sub-module stack_ptr: depth counter with inc/dec/hold and full/empty decode.
- Arbitration and FSM stay in stack_ctrl.

Test Plan:
- Push 8'h11, 8'h22, 8'h33 from reset -> writes at C0, C1, C2; depth=3; empty=0.
- Pop 3 times -> d_pop 33, 22, 11, each pulse one cycle after pop, with busy high; depth=0; empty=1; pop during busy ignored.
- Push 32 values, then push 8'hAA -> full=1, no write at E0, ovf=1. Pop on empty -> unf=1, no pop_valid. clr_err clears both.
- Push+pop with depth=2, d_push=8'h5A -> mem[C1]=5A, depth stays 2; next pop returns 5A.
- ls_req store to 8'h10 in the same cycle as push -> ls_gnt=0 and push written. Next cycle ls_gnt=1 and mem[10] written; load during POP_RD is granted.
- Assert rst_n=0 during POP_RD -> pop_valid drops immediately; depth=0; FSM IDLE; flags 0.
